// File: rtl/alpha_recursion_engine_if.sv
// Trellis description shared between a table source and the alpha recursion engine.
// next_state/outputs are indexed [state][input symbol].
interface trellis_if #(
  parameter int STATES         = 4,
  parameter int INPUT_SYMBOLS  = 2,
  parameter int OUTPUT_SYMBOLS = 4,
  localparam int SW = (STATES > 1) ? $clog2(STATES) : 1,
  localparam int OW = (OUTPUT_SYMBOLS > 1) ? $clog2(OUTPUT_SYMBOLS) : 1
);
  logic [STATES-1:0][INPUT_SYMBOLS-1:0][SW-1:0] next_state;
  logic [STATES-1:0][INPUT_SYMBOLS-1:0][OW-1:0] outputs;

  modport eng (input next_state, input outputs);
  modport tbl (output next_state, output outputs);
endinterface

// File: rtl/alpha_recursion_engine.sv
// Forward (alpha) metric recursion over a trellis, one step per accepted beat.
// Per-state add-compare-select lanes feed an optional max-normalisation stage.

module alpha_acs #(
  parameter int BITS           = 16,
  parameter int STATES         = 4,
  parameter int INPUT_SYMBOLS  = 2,
  parameter int OUTPUT_SYMBOLS = 4,
  parameter int SW             = 2,
  parameter int OW             = 2,
  parameter int NS             = 0
) (
  input  logic [STATES-1:0][BITS-1:0]                 prev,
  input  logic [OUTPUT_SYMBOLS-1:0][BITS-1:0]         bm,
  input  logic [STATES-1:0][INPUT_SYMBOLS-1:0][SW-1:0] next_state,
  input  logic [STATES-1:0][INPUT_SYMBOLS-1:0][OW-1:0] outputs,
  output logic signed [BITS-1:0]                      metric
);
  localparam logic signed [BITS-1:0] MINV  = {1'b1, {(BITS-1){1'b0}}};
  localparam logic signed [BITS-1:0] MAXV  = {1'b0, {(BITS-1){1'b1}}};
  localparam logic signed [BITS-1:0] MINP1 = {1'b1, {(BITS-2){1'b0}}, 1'b1};
  localparam logic signed [BITS:0]   HI    = {1'b0, MAXV};
  localparam logic signed [BITS:0]   LO    = {1'b1, MINP1};
  localparam logic [SW-1:0]          NSW   = SW'(NS);

  // Saturating add never produces MIN; only a MIN predecessor does.
  function automatic logic signed [BITS-1:0] sat_add(input logic [BITS-1:0] a,
                                                     input logic [BITS-1:0] b);
    logic signed [BITS:0] s;
    s = {a[BITS-1], a} + {b[BITS-1], b};
    if (s > HI)      sat_add = MAXV;
    else if (s < LO) sat_add = MINP1;
    else             sat_add = s[BITS-1:0];
  endfunction

  logic signed [BITS-1:0] cand;
  logic signed [BITS-1:0] best;

  always_comb begin
    best = MINV;
    cand = MINV;
    for (int s = 0; s < STATES; s++) begin
      for (int p = 0; p < INPUT_SYMBOLS; p++) begin
        if (next_state[s][p] == NSW) begin
          cand = ($signed(prev[s]) == MINV) ? MINV : sat_add(prev[s], bm[outputs[s][p]]);
          if (cand > best) best = cand;
        end
      end
    end
    metric = best;
  end
endmodule

module alpha_recursion_engine #(
  parameter int BITS           = 16,
  parameter int STATES         = 4,
  parameter int MAX_STEPS      = 1024,
  parameter int NORMALIZE      = 1,
  parameter int INPUT_SYMBOLS  = 2,
  parameter int OUTPUT_SYMBOLS = 4,
  localparam int IW = $clog2(MAX_STEPS),
  localparam int SW = (STATES > 1) ? $clog2(STATES) : 1,
  localparam int OW = (OUTPUT_SYMBOLS > 1) ? $clog2(OUTPUT_SYMBOLS) : 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  trellis_if.eng                             trellis,
  input  logic                               init_known,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               in_first,
  input  logic                               in_last,
  input  logic [OUTPUT_SYMBOLS-1:0][BITS-1:0] branch_metric,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_last,
  output logic [STATES-1:0][BITS-1:0]         alpha,
  output logic [IW-1:0]                      step_idx,
  output logic                               protocol_err
);
  localparam logic signed [BITS-1:0] MINV  = {1'b1, {(BITS-1){1'b0}}};
  localparam logic signed [BITS-1:0] MINP1 = {1'b1, {(BITS-2){1'b0}}, 1'b1};
  localparam logic signed [BITS:0]   LO    = {1'b1, MINP1};
  localparam logic [IW-1:0]          LAST_IDX = IW'(MAX_STEPS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                    state, state_nxt;
  logic [STATES-1:0][BITS-1:0] prev, start_vec, prev_src, new_alpha, norm_alpha;
  logic                      accept, take, restart, err_nxt;
  logic [IW-1:0]             step_nxt;
  logic signed [BITS-1:0]    mx;
  logic signed [BITS:0]      diff;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    for (int i = 0; i < STATES; i++)
      start_vec[i] = (init_known && i != 0) ? MINV : '0;
  end

  assign prev_src = restart ? start_vec : prev;

  for (genvar g = 0; g < STATES; g++) begin : g_acs
    alpha_acs #(
      .BITS(BITS), .STATES(STATES), .INPUT_SYMBOLS(INPUT_SYMBOLS),
      .OUTPUT_SYMBOLS(OUTPUT_SYMBOLS), .SW(SW), .OW(OW), .NS(g)
    ) u_acs (
      .prev(prev_src), .bm(branch_metric),
      .next_state(trellis.next_state), .outputs(trellis.outputs),
      .metric(new_alpha[g])
    );
  end

  // Shift so the best metric is 0; a huge spread clamps at MIN+1 to keep MIN reserved.
  always_comb begin
    mx         = MINV;
    diff       = '0;
    norm_alpha = new_alpha;
    for (int i = 0; i < STATES; i++)
      if ($signed(new_alpha[i]) > mx) mx = $signed(new_alpha[i]);
    if (NORMALIZE != 0 && mx != MINV) begin
      for (int i = 0; i < STATES; i++) begin
        if ($signed(new_alpha[i]) != MINV) begin
          diff = {new_alpha[i][BITS-1], new_alpha[i]} - {mx[BITS-1], mx};
          norm_alpha[i] = (diff < LO) ? MINP1 : diff[BITS-1:0];
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    restart   = 1'b0;
    err_nxt   = 1'b0;
    step_nxt  = step_idx;
    unique case (state)
      IDLE: if (accept) begin
        if (in_first) begin
          take      = 1'b1;
          restart   = 1'b1;
          step_nxt  = '0;
          state_nxt = in_last ? IDLE : RUN;
        end else begin
          err_nxt = 1'b1;
        end
      end
      RUN: if (accept) begin
        take = 1'b1;
        if (in_first) begin
          restart  = 1'b1;
          err_nxt  = 1'b1;
          step_nxt = '0;
        end else if (step_idx == LAST_IDX) begin
          err_nxt = 1'b1;
        end else begin
          step_nxt = step_idx + 1'b1;
        end
        if (in_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      protocol_err <= 1'b0;
      step_idx     <= '0;
      alpha        <= '0;
      prev         <= '0;
    end else begin
      state        <= state_nxt;
      protocol_err <= err_nxt;
      if (take) begin
        alpha     <= norm_alpha;
        prev      <= norm_alpha;
        step_idx  <= step_nxt;
        out_last  <= in_last;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alpha_recursion_engine.sv
// Scoreboard bench: three engine variants share one stimulus stream and one trellis.
// A behavioural integer model predicts each variant's outputs at beat acceptance.
module tb_alpha_recursion_engine;
  localparam int NS = 4, NI = 2, NO = 4, ND = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, init_known, in_valid, in_first, in_last, out_ready;
  int   bm_val [NO];
  logic [NO-1:0][15:0] bm16;
  logic [NO-1:0][7:0]  bm8;

  always_comb begin
    bm16 = '0;
    bm8  = '0;
    for (int i = 0; i < NO; i++) begin
      bm16[i] = 16'(bm_val[i]);
      bm8[i]  = 8'(bm_val[i]);
    end
  end

  trellis_if #(.STATES(NS), .INPUT_SYMBOLS(NI), .OUTPUT_SYMBOLS(NO)) trel ();

  logic              rdy_a, rdy_b, rdy_c, vld_a, vld_b, vld_c, lst_a, lst_b, lst_c;
  logic              err_a, err_b, err_c;
  logic [NS-1:0][15:0] alpha_a;
  logic [NS-1:0][7:0]  alpha_b, alpha_c;
  logic [9:0]        step_a, step_c;
  logic [2:0]        step_b;

  alpha_recursion_engine #(.BITS(16), .STATES(NS), .MAX_STEPS(1024), .NORMALIZE(1),
    .INPUT_SYMBOLS(NI), .OUTPUT_SYMBOLS(NO)) dut_a (
    .clk(clk), .rst_n(rst_n), .trellis(trel), .init_known(init_known),
    .in_valid(in_valid), .in_ready(rdy_a), .in_first(in_first), .in_last(in_last),
    .branch_metric(bm16), .out_valid(vld_a), .out_ready(out_ready), .out_last(lst_a),
    .alpha(alpha_a), .step_idx(step_a), .protocol_err(err_a));

  alpha_recursion_engine #(.BITS(8), .STATES(NS), .MAX_STEPS(8), .NORMALIZE(0),
    .INPUT_SYMBOLS(NI), .OUTPUT_SYMBOLS(NO)) dut_b (
    .clk(clk), .rst_n(rst_n), .trellis(trel), .init_known(init_known),
    .in_valid(in_valid), .in_ready(rdy_b), .in_first(in_first), .in_last(in_last),
    .branch_metric(bm8), .out_valid(vld_b), .out_ready(out_ready), .out_last(lst_b),
    .alpha(alpha_b), .step_idx(step_b), .protocol_err(err_b));

  alpha_recursion_engine #(.BITS(8), .STATES(NS), .MAX_STEPS(1024), .NORMALIZE(1),
    .INPUT_SYMBOLS(NI), .OUTPUT_SYMBOLS(NO)) dut_c (
    .clk(clk), .rst_n(rst_n), .trellis(trel), .init_known(init_known),
    .in_valid(in_valid), .in_ready(rdy_c), .in_first(in_first), .in_last(in_last),
    .branch_metric(bm8), .out_valid(vld_c), .out_ready(out_ready), .out_last(lst_c),
    .alpha(alpha_c), .step_idx(step_c), .protocol_err(err_c));

  int obs_alpha [ND][NS];
  int obs_step  [ND];
  int obs_valid [ND], obs_last [ND], obs_err [ND], obs_ready [ND];

  always_comb begin
    for (int i = 0; i < NS; i++) begin
      obs_alpha[0][i] = int'($signed(alpha_a[i]));
      obs_alpha[1][i] = int'($signed(alpha_b[i]));
      obs_alpha[2][i] = int'($signed(alpha_c[i]));
    end
    obs_step  = '{int'(step_a), int'(step_b), int'(step_c)};
    obs_valid = '{int'(vld_a), int'(vld_b), int'(vld_c)};
    obs_last  = '{int'(lst_a), int'(lst_b), int'(lst_c)};
    obs_err   = '{int'(err_a), int'(err_b), int'(err_c)};
    obs_ready = '{int'(rdy_a), int'(rdy_b), int'(rdy_c)};
  end

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // ---------------- model ----------------
  typedef struct packed {
    logic [NS-1:0][31:0] a;
    logic [31:0]         step;
    logic                last;
  } exp_t;

  exp_t sbq [ND][$];
  exp_t mon_e;

  int ns_tab  [NS][NI];
  int out_tab [NS][NI];
  int m_bits [ND] = '{16, 8, 8};
  int m_max  [ND] = '{1024, 8, 1024};
  int m_norm [ND] = '{1, 0, 1};
  int m_run  [ND];
  int m_step [ND];
  int m_prev [ND][NS];
  int exp_err [ND];

  task automatic model_accept(input int d);
    int minv, maxv, c, mx;
    int src [NS];
    int nxt [NS];
    exp_t e;
    minv = -(1 << (m_bits[d] - 1));
    maxv = -minv - 1;
    exp_err[d] = 0;
    if (in_first) begin
      if (m_run[d] != 0) exp_err[d] = 1;
      for (int i = 0; i < NS; i++) src[i] = (init_known && i != 0) ? minv : 0;
      m_step[d] = 0;
    end else if (m_run[d] == 0) begin
      exp_err[d] = 1;
      return;
    end else begin
      for (int i = 0; i < NS; i++) src[i] = m_prev[d][i];
      if (m_step[d] == m_max[d] - 1) exp_err[d] = 1;
      else m_step[d]++;
    end
    for (int n = 0; n < NS; n++) begin
      nxt[n] = minv;
      for (int s = 0; s < NS; s++)
        for (int p = 0; p < NI; p++)
          if (ns_tab[s][p] == n) begin
            if (src[s] == minv) c = minv;
            else begin
              c = src[s] + bm_val[out_tab[s][p]];
              if (c > maxv) c = maxv;
              if (c < minv + 1) c = minv + 1;
            end
            if (c > nxt[n]) nxt[n] = c;
          end
    end
    mx = minv;
    for (int i = 0; i < NS; i++) if (nxt[i] > mx) mx = nxt[i];
    if (m_norm[d] != 0 && mx != minv)
      for (int i = 0; i < NS; i++)
        if (nxt[i] != minv) begin
          nxt[i] = nxt[i] - mx;
          if (nxt[i] < minv + 1) nxt[i] = minv + 1;
        end
    for (int i = 0; i < NS; i++) begin
      m_prev[d][i] = nxt[i];
      e.a[i] = 32'(nxt[i]);
    end
    e.step = 32'(m_step[d]);
    e.last = in_last;
    m_run[d] = in_last ? 0 : 1;
    sbq[d].push_back(e);
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_run[d] = 0;
      m_step[d] = 0;
      sbq[d].delete();
    end
  endtask

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < ND; d++) begin
        if (obs_valid[d] != 0) begin
          if (sbq[d].size() == 0) begin
            chk($sformatf("unexpected_out_d%0d", d), obs_valid[d], 0);
          end else begin
            mon_e = sbq[d][0];
            for (int i = 0; i < NS; i++)
              chk($sformatf("alpha_d%0d_s%0d_step%0d", d, i, int'(mon_e.step)),
                  obs_alpha[d][i], int'($signed(mon_e.a[i])));
            chk($sformatf("step_idx_d%0d", d), obs_step[d], int'(mon_e.step));
            chk($sformatf("out_last_d%0d", d), obs_last[d], int'(mon_e.last));
            if (out_ready) void'(sbq[d].pop_front());
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_bm(input int mode, input int v);
    for (int i = 0; i < NO; i++)
      bm_val[i] = (mode == 0) ? v : $urandom_range(2 * v, 0) - v;
  endtask

  task automatic send_beat(input bit f, input bit l, input int mode, input int v);
    bit acc;
    in_first = f;
    in_last  = l;
    set_bm(mode, v);
    in_valid = 1'b1;
    for (int n = 0; n <= 50; n++) begin
      @(negedge clk);
      acc = (obs_ready[0] != 0) && rst_n;
      if (acc) for (int d = 0; d < ND; d++) model_accept(d);
      @(posedge clk);
      #1;
      if (acc) begin
        for (int d = 0; d < ND; d++)
          chk($sformatf("protocol_err_d%0d", d), obs_err[d], exp_err[d]);
        break;
      end
      if (n == 50) chk("accept_timeout", 0, 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic frame(input int len, input bit ik, input int mode, input int v);
    init_known = ik;
    for (int k = 0; k < len; k++) send_beat(k == 0, k == len - 1, mode, v);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int s = 0; s < NS; s++)
      for (int p = 0; p < NI; p++) begin
        ns_tab[s][p]  = ((s << 1) | p) & 3;
        out_tab[s][p] = (((p ^ (s >> 1)) & 1) << 1) | ((p ^ (s >> 1) ^ s) & 1);
        trel.next_state[s][p] = 2'(ns_tab[s][p]);
        trel.outputs[s][p]    = 2'(out_tab[s][p]);
      end
    rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    init_known = 1'b0; out_ready = 1'b1;
    set_bm(0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rst_out_valid_d%0d", d), obs_valid[d], 0);
      chk($sformatf("rst_in_ready_d%0d", d), obs_ready[d], 1);
      chk($sformatf("rst_step_d%0d", d), obs_step[d], 0);
      chk($sformatf("rst_err_d%0d", d), obs_err[d], 0);
      chk($sformatf("rst_alpha0_d%0d", d), obs_alpha[d][0], 0);
    end
    rst_n = 1'b1;
    idle(2);

    // beat without first in IDLE: error pulse, nothing emitted
    send_beat(0, 0, 0, 0);
    @(negedge clk);
    chk("idle_no_first_valid", obs_valid[0], 0);
    idle(1);

    frame(3, 1, 0, 0);     // known start, zero metrics
    idle(2);
    frame(4, 0, 0, 100);   // saturation / normalisation
    idle(2);
    frame(6, 1, 1, 60);    // random metrics, back-to-back
    idle(1);

    // backpressure: hold out_ready low for 3 cycles with a beat pending
    init_known = 1'b1;
    send_beat(1, 0, 1, 50);
    send_beat(0, 0, 1, 50);
    out_ready = 1'b0;
    fork
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready", obs_ready[0], 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join_none
    send_beat(0, 0, 1, 50);
    send_beat(0, 1, 1, 50);
    idle(2);

    // first mid-frame: restart
    init_known = 1'b0;
    send_beat(1, 0, 1, 40);
    send_beat(0, 0, 1, 40);
    init_known = 1'b1;
    send_beat(1, 0, 1, 40);
    send_beat(0, 1, 1, 40);
    idle(2);

    frame(10, 0, 1, 30);   // overruns the MAX_STEPS=8 variant
    idle(1);
    frame(1, 1, 1, 20);    // one-step frame
    idle(1);

    // reset mid-frame at step 5
    init_known = 1'b1;
    for (int k = 0; k < 6; k++) send_beat(k == 0, 0, 1, 30);
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("midrst_out_valid_d%0d", d), obs_valid[d], 0);
      chk($sformatf("midrst_step_d%0d", d), obs_step[d], 0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
    frame(3, 1, 1, 30);

    for (int n = 0; n < 20; n++) begin
      if (sbq[0].size() == 0 && sbq[1].size() == 0 && sbq[2].size() == 0) break;
      @(posedge clk);
      #1;
    end
    for (int d = 0; d < ND; d++)
      chk($sformatf("drain_d%0d", d), sbq[d].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alpha_recursion_engine.md
ALPHA_RECURSION_ENGINE -- requirements
Module: alpha_recursion_engine

Interface
REQ-001 The block SHALL have the parameter BITS, default 16, which is the signed two's-complement metric width.
REQ-002 The block SHALL have the parameter STATES, default 4, which is the number of trellis states (power of 2, 2..16).
REQ-003 The block SHALL have the parameter MAX_STEPS, default 1024, which is the longest frame in trellis steps.
REQ-004 The block SHALL have the parameter NORMALIZE, default 1; 1 = subtract the per-step maximum, 0 = none.
REQ-005 The block SHALL have the port clk, input, width 1, the single clock (rising edge).
REQ-006 The block SHALL have the port rst_n, input, width 1: asynchronous, active-low reset.
REQ-007 The block SHALL have the port trellis, a trellis_if instance supplying STATES, INPUT_SYMBOLS, OUTPUT_SYMBOLS, next_state[][] and outputs[][].
REQ-008 The block SHALL have the port init_known, input, width 1; it is sampled on a first beat: 1 = start in state 0, 0 = unknown start.
REQ-009 The block SHALL have the following input handshake ports: in_valid (in, 1), in_ready (out, 1), in_first (in, 1) and in_last (in, 1).
REQ-010 The block SHALL have the port branch_metric, input, an array [OUTPUT_SYMBOLS] of BITS, holding the metrics for one trellis step.
REQ-011 The block SHALL have the following output handshake ports: out_valid (out, 1), out_ready (in, 1) and out_last (out, 1).
REQ-012 The block SHALL have the port alpha, output, an array [STATES] of BITS, the forward metrics after the step.
REQ-013 The block SHALL have the port step_idx, output, width $clog2(MAX_STEPS), the index of the step in alpha.
REQ-014 The block SHALL have the port protocol_err, output, width 1: a one-cycle pulse on a framing violation.

Function
REQ-015 The block SHALL have the FSM states IDLE and RUN; a beat is accepted when in_valid && in_ready.
REQ-016 in_ready SHALL equal !out_valid || out_ready, in both states.
REQ-017 In IDLE, an accepted beat with in_first=1 SHALL load the start vector and enter RUN.
REQ-018 The start vector SHALL be as follows: with init_known=1, state 0 = 0 and all other states = MIN; with init_known=0, all states = 0.
REQ-019 In IDLE, an accepted beat with in_first=0 SHALL be discarded, SHALL pulse protocol_err, and SHALL produce no output.
REQ-020 Every accepted beat processed in RUN, including the first beat, SHALL compute new_alpha[ns] = max over (s,p) with next_state[s][p]=ns of sat_add(prev[s], branch_metric[outputs[s][p]]); a state with no incoming candidate gets MIN.
REQ-021 MIN SHALL be -2^(BITS-1) and SHALL be sticky: if prev[s]==MIN, that candidate is MIN regardless of the branch metric.
REQ-022 sat_add SHALL clamp to [MIN+1, 2^(BITS-1)-1]; only the sticky rule yields MIN.
REQ-023 With NORMALIZE=1, every non-MIN new_alpha SHALL have the maximum new_alpha subtracted, so the largest metric equals 0; MIN entries stay MIN.
REQ-024 The result SHALL be registered into alpha and into the internal prev register in the same edge; out_valid SHALL assert the cycle after acceptance (latency 1), which gives a throughput of one step per cycle when out_ready=1.
REQ-025 While out_valid=1 and out_ready=0, the outputs alpha, step_idx and out_last SHALL hold stable.
REQ-026 out_valid SHALL clear on the handshake when no new beat is accepted in the same cycle.
REQ-027 step_idx SHALL be 0 for the first beat and SHALL increment per accepted beat.
REQ-028 If step_idx would reach MAX_STEPS without in_last, the beat SHALL be processed, step_idx SHALL hold at MAX_STEPS-1, and protocol_err SHALL pulse.
REQ-029 out_last SHALL equal the registered in_last; acceptance of a beat with in_last SHALL return the FSM to IDLE.
REQ-030 A beat with both in_first and in_last SHALL be a one-step frame.
REQ-031 In RUN, a beat with in_first=1 SHALL pulse protocol_err and SHALL restart the frame: reload the start vector, set step_idx to 0, and process the beat.

Reset
REQ-032 While rst_n=0, asynchronously: FSM = IDLE, out_valid = 0, out_last = 0, protocol_err = 0, step_idx = 0, alpha = all 0, prev = all 0; in_ready = 1 after reset.
REQ-033 Reset mid-frame SHALL drop the frame and emit no further outputs; the next frame SHALL require in_first.

Verification
REQ-034 Known start: STATES=4, BITS=16, init_known=1, all branch_metric=0, 3-beat frame -> step 0 gives 0 at next_state[0][*] and -32768 elsewhere; by step 2 all four states = 0; out_last only on step 2.
REQ-035 Saturation: BITS=8, NORMALIZE=0, init_known=0, all branch_metric=100 -> step 0 all 100, step 1 all 127, and the values stay 127.
REQ-036 Normalisation: same stimulus with NORMALIZE=1 -> every step gives all 0.
REQ-037 Backpressure: out_ready=0 for 3 cycles mid-frame -> in_ready=0, alpha and step_idx stable, no beat lost or duplicated, step_idx sequence contiguous.
REQ-038 Framing: a beat without in_first in IDLE -> protocol_err pulse, no out_valid; in_first mid-frame -> protocol_err pulse and step_idx=0 on the next output.
REQ-039 Reset: rst_n low for 1 cycle at step 5 -> out_valid=0 immediately; a new frame gives step_idx 0 with the correct start vector.
